// File: rtl/bp_hidden_layer_scheduler_pkg.sv
// Shared types and helpers for the hidden-layer back-prop scheduler.
package bp_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_DELTA,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    localparam logic [31:0] FP_ONE = 32'h3F800000;

    // Weight RAM is laid out row-major over forward nodes with a trailing bias column per row.
    function automatic int unsigned weight_addr(input int unsigned k,
                                                input int unsigned n,
                                                input int unsigned h);
        return k * (h + 1) + n;
    endfunction

endpackage

// File: rtl/bp_hidden_layer_scheduler_if.sv
// Operand/result bus between the scheduler (master) and the shared back-prop datapath (slave).
interface bp_hidden_layer_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  dp_valid;
    logic                  dp_ready;
    logic                  dp_first;
    logic                  dp_last;
    logic [DATA_WIDTH-1:0] dp_delta;
    logic [DATA_WIDTH-1:0] dp_weight;
    logic [DATA_WIDTH-1:0] dp_act;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;

    modport master (
        output dp_valid, dp_first, dp_last, dp_delta, dp_weight, dp_act,
        input  dp_ready, res_valid, res_data
    );

    modport slave (
        input  dp_valid, dp_first, dp_last, dp_delta, dp_weight, dp_act,
        output dp_ready, res_valid, res_data
    );
endinterface

// File: rtl/bp_hidden_layer_scheduler_operand.sv
// One-deep stall-safe operand register; weight/activation arrive from 1-cycle-latency RAMs
// and are passed through on the landing cycle, then held locally while stalled.
module bp_operand_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] issue_delta,
    input  logic                  issue_first,
    input  logic                  issue_last,
    input  logic [DATA_WIDTH-1:0] ram_weight,
    input  logic [DATA_WIDTH-1:0] ram_act,
    input  logic                  ready,
    output logic                  can_issue,
    output logic                  valid,
    output logic                  first,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] delta,
    output logic [DATA_WIDTH-1:0] weight,
    output logic [DATA_WIDTH-1:0] act
);
    logic                  valid_reg;
    logic                  fresh_reg;
    logic                  first_reg;
    logic                  last_reg;
    logic [DATA_WIDTH-1:0] delta_reg;
    logic [DATA_WIDTH-1:0] weight_hold_reg;
    logic [DATA_WIDTH-1:0] act_hold_reg;

    assign can_issue = !valid_reg || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg       <= 1'b0;
            fresh_reg       <= 1'b0;
            first_reg       <= 1'b0;
            last_reg        <= 1'b0;
            delta_reg       <= '0;
            weight_hold_reg <= '0;
            act_hold_reg    <= '0;
        end else begin
            if (issue) begin
                valid_reg <= 1'b1;
                fresh_reg <= 1'b1;
                first_reg <= issue_first;
                last_reg  <= issue_last;
                delta_reg <= issue_delta;
            end else begin
                fresh_reg <= 1'b0;
                if (ready) begin
                    valid_reg <= 1'b0;
                end
            end
            // RAM data is only guaranteed on its landing cycle; keep a copy for stalls.
            if (fresh_reg) begin
                weight_hold_reg <= ram_weight;
                act_hold_reg    <= ram_act;
            end
        end
    end

    assign valid  = valid_reg;
    assign first  = first_reg;
    assign last   = last_reg;
    assign delta  = delta_reg;
    assign weight = fresh_reg ? ram_weight : weight_hold_reg;
    assign act    = fresh_reg ? ram_act    : act_hold_reg;

endmodule

// File: rtl/bp_hidden_layer_scheduler.sv
// Hidden-layer back-prop scheduler: loads output deltas, streams operand pairs to the shared
// datapath and writes returned results to the hidden delta RAM. Optional: BP_SCHED_STALL_CNT_EN.
module bp_hidden_layer_scheduler
    import bp_sched_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int NUMBER_OF_HIDDEN_NODE  = 4,
    parameter int NUMBER_OF_FORWARD_NODE = 3,
    parameter int ADDRESS_WIDTH          = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_delta_rd,
    output logic [ADDRESS_WIDTH-1:0] o_delta_addr,
    input  logic [DATA_WIDTH-1:0]    i_delta_data,
    output logic                     o_weight_rd,
    output logic [ADDRESS_WIDTH-1:0] o_weight_addr,
    input  logic [DATA_WIDTH-1:0]    i_weight_data,
    output logic                     o_act_rd,
    output logic [ADDRESS_WIDTH-1:0] o_act_addr,
    input  logic [DATA_WIDTH-1:0]    i_act_data,
    bp_hidden_layer_scheduler_if.master dp,
    output logic                     o_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]    o_wr_data,
    output logic                     o_overflow_err,
    output logic [15:0]              o_stall_count
);
    localparam int H = NUMBER_OF_HIDDEN_NODE;
    localparam int F = NUMBER_OF_FORWARD_NODE;
    localparam logic [ADDRESS_WIDTH-1:0] H_A    = ADDRESS_WIDTH'(H);
    localparam logic [ADDRESS_WIDTH-1:0] F_A    = ADDRESS_WIDTH'(F);
    localparam logic [ADDRESS_WIDTH-1:0] H_LAST = ADDRESS_WIDTH'(H - 1);
    localparam logic [ADDRESS_WIDTH-1:0] F_LAST = ADDRESS_WIDTH'(F - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE_A  = ADDRESS_WIDTH'(1);

    sched_state_t state_reg, state_next;

    logic [ADDRESS_WIDTH-1:0] ld_cnt_reg;
    logic                     cap_valid_reg;
    logic [ADDRESS_WIDTH-1:0] cap_idx_reg;
    logic [ADDRESS_WIDTH-1:0] n_reg;
    logic [ADDRESS_WIDTH-1:0] k_reg;
    logic [ADDRESS_WIDTH-1:0] res_cnt_reg;
    logic [ADDRESS_WIDTH-1:0] res_cnt_next;
    logic                     overflow_reg;

    logic                     start_accept;
    logic                     delta_rd;
    logic                     issue;
    logic                     can_issue;
    logic                     last_pair;
    logic                     res_accept;
    logic                     res_wr;
    logic [DATA_WIDTH-1:0]    rf_entry [F];
    logic [DATA_WIDTH-1:0]    rf_sel;

    assign start_accept = (state_reg == ST_IDLE) && i_start;
    assign last_pair    = (k_reg == F_LAST) && (n_reg == H_LAST);
    assign res_accept   = (state_reg != ST_IDLE) && (res_cnt_reg != H_A);
    assign res_wr       = dp.res_valid && res_accept;
    assign res_cnt_next = res_wr ? res_cnt_reg + ONE_A : res_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        delta_rd   = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_LOAD_DELTA;
                end
            end
            ST_LOAD_DELTA: begin
                o_busy   = 1'b1;
                delta_rd = (ld_cnt_reg < F_A);
                // The final capture lands on the same edge that enters ISSUE.
                if (ld_cnt_reg == F_A) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_busy = 1'b1;
                issue  = can_issue;
                if (can_issue && last_pair) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (res_cnt_next == H_A) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_reg    <= '0;
            cap_valid_reg <= 1'b0;
            cap_idx_reg   <= '0;
            n_reg         <= '0;
            k_reg         <= '0;
            res_cnt_reg   <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            cap_valid_reg <= delta_rd;
            cap_idx_reg   <= ld_cnt_reg;
            if (start_accept) begin
                ld_cnt_reg  <= '0;
                n_reg       <= '0;
                k_reg       <= '0;
                res_cnt_reg <= '0;
            end else begin
                if (state_reg == ST_LOAD_DELTA) begin
                    ld_cnt_reg <= ld_cnt_reg + ONE_A;
                end
                if (issue) begin
                    if (k_reg == F_LAST) begin
                        k_reg <= '0;
                        n_reg <= n_reg + ONE_A;
                    end else begin
                        k_reg <= k_reg + ONE_A;
                    end
                end
                res_cnt_reg <= res_cnt_next;
            end
            if (dp.res_valid && !res_accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Output-layer delta register file, one entry per forward node.
    for (genvar gi = 0; gi < F; gi++) begin : g_rf
        logic [DATA_WIDTH-1:0] entry_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= '0;
            end else if (cap_valid_reg && (cap_idx_reg == ADDRESS_WIDTH'(gi))) begin
                entry_reg <= i_delta_data;
            end
        end
        assign rf_entry[gi] = entry_reg;
    end

    always_comb begin
        rf_sel = '0;
        for (int i = 0; i < F; i++) begin
            if (k_reg == ADDRESS_WIDTH'(i)) begin
                rf_sel = rf_entry[i];
            end
        end
    end

    bp_operand_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_operand_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .issue_delta (rf_sel),
        .issue_first (k_reg == '0),
        .issue_last  (k_reg == F_LAST),
        .ram_weight  (i_weight_data),
        .ram_act     (i_act_data),
        .ready       (dp.dp_ready),
        .can_issue   (can_issue),
        .valid       (dp.dp_valid),
        .first       (dp.dp_first),
        .last        (dp.dp_last),
        .delta       (dp.dp_delta),
        .weight      (dp.dp_weight),
        .act         (dp.dp_act)
    );

    assign o_delta_rd     = delta_rd;
    assign o_delta_addr   = delta_rd ? ld_cnt_reg : '0;
    assign o_weight_rd    = issue;
    assign o_weight_addr  = issue ? ADDRESS_WIDTH'(weight_addr(32'(k_reg), 32'(n_reg), H)) : '0;
    assign o_act_rd       = issue;
    assign o_act_addr     = issue ? n_reg : '0;
    assign o_wr_en        = res_wr;
    assign o_wr_addr      = res_wr ? res_cnt_reg : '0;
    assign o_wr_data      = res_wr ? dp.res_data : '0;
    assign o_overflow_err = overflow_reg;

`ifdef BP_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (start_accept) begin
            stall_cnt_reg <= '0;
        end else if (dp.dp_valid && !dp.dp_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign o_stall_count = stall_cnt_reg;
`else
    assign o_stall_count = 16'h0000;
`endif

endmodule

// File: doc/bp_hidden_layer_scheduler.md
Name: bp_hidden_layer_scheduler

Overview:
Sequences the hidden-layer back-propagation for one training step.
- Loads the output-layer delta vector once.
- Streams (delta, weight, activation) operand pairs, one hidden node at a time, into a shared pipelined MAC / leaky-ReLU-derivative datapath.
- Collects the in-order results and writes them to the hidden delta RAM.
- Sits between the main weight/delta/activation RAMs and the single shared back-prop datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width (IEEE-754 single).
- NUMBER_OF_HIDDEN_NODE, 4, hidden nodes H (results produced).
- NUMBER_OF_FORWARD_NODE, 3, forward nodes F (products per hidden node).
- ADDRESS_WIDTH, 11, RAM address width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, start pulse; ignored while busy.
- o_busy, out, 1, high from accepted start until done.
- o_done, out, 1, one-cycle pulse after last result written.
- o_delta_rd / o_delta_addr, out, 1 / ADDRESS_WIDTH, forward delta RAM read; data returned 1 cycle later.
- i_delta_data, in, DATA_WIDTH, delta RAM data.
- o_weight_rd / o_weight_addr, out, 1 / ADDRESS_WIDTH, weight RAM read, latency 1.
- i_weight_data, in, DATA_WIDTH, weight RAM data.
- o_act_rd / o_act_addr, out, 1 / ADDRESS_WIDTH, hidden activation RAM read, latency 1.
- i_act_data, in, DATA_WIDTH, activation data.
- o_dp_valid, out, 1, operand pair valid.
- i_dp_ready, in, 1, datapath accepts pair.
- o_dp_first / o_dp_last, out, 1 / 1, first/last product of current hidden node.
- o_dp_delta / o_dp_weight / o_dp_act, out, DATA_WIDTH each, operands; o_dp_act meaningful with o_dp_last.
- i_res_valid / i_res_data, in, 1 / DATA_WIDTH, datapath result, in hidden-node order.
- o_wr_en / o_wr_addr / o_wr_data, out, 1 / ADDRESS_WIDTH / DATA_WIDTH, hidden delta RAM write.
- o_overflow_err, out, 1, sticky: result received beyond H or outside a run.
- o_stall_count, out, 16, stall counter (see Optional Feature).

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- Reset mid-operation: aborts the run; no done pulse.

FSM states:
- IDLE: i_start sets o_busy and goes to LOAD_DELTA.
- LOAD_DELTA: issues delta reads at addresses 0..F-1 on consecutive cycles; data captured into an F-entry register file 1 cycle later. Goes to ISSUE after the last capture (F+1 cycles).
- ISSUE: n outer 0..H-1, k inner 0..F-1.
  - Weight address = k*(H+1)+n; the bias column n=H is never read.
  - Activation address = n.
  - Delta taken from register file[k].
- DRAIN: waits until the result count reaches H.
- DONE: o_done=1 for one cycle, o_busy=0, back to IDLE.

Issue pipeline (two stages: fetch address, output register):
- Reads are asserted only when the output register will be free next cycle: empty, or (o_dp_valid & i_dp_ready).
- o_dp_* hold stable while o_dp_valid & !i_dp_ready.
- No pair is lost or duplicated.
- o_dp_first = (k==0); o_dp_last = (k==F-1).
- Full throughput: one pair per cycle when ready is held high.

Results:
- Each i_res_valid writes o_wr_en=1, o_wr_addr=result count, o_wr_data=i_res_data in the same cycle (combinational pass-through, registered count).
- Results may arrive during ISSUE.
- A result arriving while result count==H, or in IDLE, is not written and sets o_overflow_err.
- o_overflow_err clears only on reset.

Simultaneous events:
- i_start while busy: ignored.
- A result write and the final issue may coincide in one cycle; both are honoured.

Optional Feature:
- Macro BP_SCHED_STALL_CNT_EN.
- Defined: o_stall_count increments each cycle with o_dp_valid & !i_dp_ready, saturates at 16'hFFFF, and clears on accepted i_start.
- Undefined: o_stall_count is constant 0 and no counter logic is built.

Decomposition:
- Shared package bp_sched_pkg: FSM state encoding (IDLE, LOAD_DELTA, ISSUE, DRAIN, DONE), localparam FP_ONE=32'h3F800000, and a weight-address helper function (k*(H+1)+n).
- One sub-module is natural: bp_operand_stage, the stall-safe 1-deep output register with RAM-latency alignment.

Test Plan (all with H=4, F=3 unless noted):
1. Start with ready held high -> deltas read at 0,1,2; exactly 12 pairs issued on consecutive cycles; pair (n=2,k=1) has weight address 7 and act address 2; first/last flag pattern is 1,0,0 / 0,0,1 per node.
2. Ready toggles 1,0,0,1 randomly -> operand stream identical to test 1; o_dp_* stable during stalls; with BP_SCHED_STALL_CNT_EN, o_stall_count equals the number of stall cycles.
3. Four results, each 20 cycles after its node's last pair, data 32'h3F000000+n -> writes at addresses 0..3 with matching data; o_done pulses exactly once, 1 cycle after the 4th write.
4. Fifth i_res_valid injected after done -> no write, o_overflow_err=1 and remains 1.
5. i_start re-pulsed during ISSUE -> ignored, still exactly 12 pairs; rst_n low during ISSUE -> all outputs 0 and IDLE next cycle; a following start completes normally.
6. H=1, F=1 -> one pair with first=last=1, weight address 0; done after the single result.
